// File: rtl/sseg_scan_capture.sv
// Receive-side monitor for a 4-digit multiplexed active-low 7-segment bus.
// Samples each digit once settled, decodes glyphs to nibbles, emits whole frames.
module sseg_scan_capture #(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [6:0]  sseg,
  input  logic        dp,
  output logic [15:0] frame_value,
  output logic [3:0]  frame_dp,
  output logic [3:0]  seg_err,
  output logic        frame_valid,
  output logic        frame_changed,
  output logic        an_err,
  output logic        stale
);

  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [0:0] {StIdle, StCollect} state_e;

  state_e         state_q, state_d;
  logic [11:0]    bus_q, bus_prev_q;
  logic [7:0]     settle_q, settle_d;
  logic [ToW-1:0] to_q, to_d;
  logic [3:0]     mask_q, mask_d;
  logic [15:0]    slot_val_q, slot_val_d;
  logic [3:0]     slot_dp_q, slot_dp_d, slot_err_q, slot_err_d;
  logic [15:0]    frame_value_q, frame_value_d;
  logic [3:0]     frame_dp_q, frame_dp_d, seg_err_q, seg_err_d;
  logic           frame_valid_q, frame_valid_d, frame_changed_q, frame_changed_d;
  logic           an_err_q, an_err_d, stale_q, stale_d;

  logic       changed, strobe, blank, onehot, valid;
  logic [3:0] an_s;
  logic [4:0] dec;

  // Returns {err, nibble}; unknown glyphs decode to 0 with err set.
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    case (s)
      7'b1000000: seg_decode = 5'h00;
      7'b1111001: seg_decode = 5'h01;
      7'b0100100: seg_decode = 5'h02;
      7'b0110000: seg_decode = 5'h03;
      7'b0011001: seg_decode = 5'h04;
      7'b0010010: seg_decode = 5'h05;
      7'b0000010: seg_decode = 5'h06;
      7'b1111000: seg_decode = 5'h07;
      7'b0000000: seg_decode = 5'h08;
      7'b0010000: seg_decode = 5'h09;
      7'b0001000: seg_decode = 5'h0a;
      7'b0000011: seg_decode = 5'h0b;
      7'b1000110: seg_decode = 5'h0c;
      7'b0100001: seg_decode = 5'h0d;
      7'b0000110: seg_decode = 5'h0e;
      7'b0001110: seg_decode = 5'h0f;
      default:    seg_decode = 5'h10;
    endcase
  endfunction

  always_comb begin
    // The strobe cycle sees the new bus in bus_q, so classify the settled copy.
    an_s    = bus_prev_q[11:8];
    dec     = seg_decode(bus_prev_q[7:1]);
    changed = (bus_q != bus_prev_q);
    strobe  = (settle_q == 8'(SETTLE_CYCLES - 1));
    blank   = (an_s == 4'b1111);
    onehot  = (an_s == 4'b1110) || (an_s == 4'b1101) || (an_s == 4'b1011) ||
              (an_s == 4'b0111);
    valid   = strobe && onehot;
  end

  always_comb begin
    state_d         = state_q;
    to_d            = to_q;
    mask_d          = mask_q;
    slot_val_d      = slot_val_q;
    slot_dp_d       = slot_dp_q;
    slot_err_d      = slot_err_q;
    frame_value_d   = frame_value_q;
    frame_dp_d      = frame_dp_q;
    seg_err_d       = seg_err_q;
    frame_valid_d   = 1'b0;
    frame_changed_d = 1'b0;
    stale_d         = 1'b0;
    an_err_d        = strobe && !blank && !onehot;

    if (changed) begin
      settle_d = '0;
    end else if (settle_q == 8'(SETTLE_CYCLES)) begin
      settle_d = settle_q;
    end else begin
      settle_d = settle_q + 8'd1;
    end

    if (valid) begin
      mask_d = mask_q | ~an_s;
      for (int i = 0; i < 4; i++) begin
        if (!an_s[i]) begin
          slot_val_d[i*4 +: 4] = dec[3:0];
          slot_dp_d[i]         = ~bus_prev_q[0];
          slot_err_d[i]        = dec[4];
        end
      end
    end

    unique case (state_q)
      StIdle: begin
        to_d = '0;
        if (valid) state_d = StCollect;
      end
      StCollect: begin
        if (mask_q == 4'b1111) begin
          frame_value_d   = slot_val_q;
          frame_dp_d      = slot_dp_q;
          seg_err_d       = slot_err_q;
          frame_valid_d   = 1'b1;
          frame_changed_d = (slot_val_q != frame_value_q);
          // A sample landing on the update cycle opens the next frame.
          mask_d          = valid ? ~an_s : 4'b0000;
          state_d         = valid ? StCollect : StIdle;
          to_d            = '0;
        end else if (valid) begin
          to_d = '0;
        end else if (to_q == ToW'(TIMEOUT_CYCLES - 1)) begin
          mask_d  = 4'b0000;
          stale_d = 1'b1;
          state_d = StIdle;
          to_d    = '0;
        end else begin
          to_d = to_q + ToW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= StIdle;
      bus_q           <= '0;
      bus_prev_q      <= '0;
      settle_q        <= '0;
      to_q            <= '0;
      mask_q          <= '0;
      slot_val_q      <= '0;
      slot_dp_q       <= '0;
      slot_err_q      <= '0;
      frame_value_q   <= '0;
      frame_dp_q      <= '0;
      seg_err_q       <= '0;
      frame_valid_q   <= 1'b0;
      frame_changed_q <= 1'b0;
      an_err_q        <= 1'b0;
      stale_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      bus_q           <= {an, sseg, dp};
      bus_prev_q      <= bus_q;
      settle_q        <= settle_d;
      to_q            <= to_d;
      mask_q          <= mask_d;
      slot_val_q      <= slot_val_d;
      slot_dp_q       <= slot_dp_d;
      slot_err_q      <= slot_err_d;
      frame_value_q   <= frame_value_d;
      frame_dp_q      <= frame_dp_d;
      seg_err_q       <= seg_err_d;
      frame_valid_q   <= frame_valid_d;
      frame_changed_q <= frame_changed_d;
      an_err_q        <= an_err_d;
      stale_q         <= stale_d;
    end
  end

  assign frame_value   = frame_value_q;
  assign frame_dp      = frame_dp_q;
  assign seg_err       = seg_err_q;
  assign frame_valid   = frame_valid_q;
  assign frame_changed = frame_changed_q;
  assign an_err        = an_err_q;
  assign stale         = stale_q;

endmodule

// File: tb/tb_sseg_scan_capture.sv
// Directed bench for sseg_scan_capture: expected frames are queued as scans are
// driven and compared whenever the DUT pulses frame_valid.
module tb_sseg_scan_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  an = 4'hf;
  logic [6:0]  sseg = 7'h7f;
  logic        dp = 1'b1;
  logic [15:0] frame_value;
  logic [3:0]  frame_dp, seg_err;
  logic        frame_valid, frame_changed, an_err, stale;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dpl;
    logic [3:0]  err;
    logic        chg;
  } frame_t;

  frame_t      exp_q[$];
  logic [15:0] last_value = 16'h0;
  int          n_total = 0, n_pass = 0, n_fail = 0;
  int          fv_cnt = 0, an_err_cnt = 0, stale_cnt = 0;

  sseg_scan_capture #(
    .SETTLE_CYCLES (4),
    .TIMEOUT_CYCLES(32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .an           (an),
    .sseg         (sseg),
    .dp           (dp),
    .frame_value  (frame_value),
    .frame_dp     (frame_dp),
    .seg_err      (seg_err),
    .frame_valid  (frame_valid),
    .frame_changed(frame_changed),
    .an_err       (an_err),
    .stale        (stale)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b1000000;  4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;  4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;  4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;  4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;  4'h9: glyph = 7'b0010000;
      4'ha: glyph = 7'b0001000;  4'hb: glyph = 7'b0000011;
      4'hc: glyph = 7'b1000110;  4'hd: glyph = 7'b0100001;
      4'he: glyph = 7'b0000110;  default: glyph = 7'b0001110;
    endcase
  endfunction

  function automatic void push_exp(input logic [15:0] v, input logic [3:0] d,
                                   input logic [3:0] e);
    frame_t f;
    f.value = v;
    f.dpl   = d;
    f.err   = e;
    f.chg   = (v != last_value);
    last_value = v;
    exp_q.push_back(f);
  endfunction

  // Each call leaves the bus value in place for exactly n rising edges.
  task automatic drive(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
    an = a;
    sseg = s;
    dp = d;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drive_digit(input int k, input logic [3:0] nib, input logic lit,
                             input int n);
    logic [3:0] a;
    a = 4'hf;
    a[k] = 1'b0;
    drive(a, glyph(nib), ~lit, n);
  endtask

  task automatic scan(input logic [15:0] v, input logic [3:0] lit, input int hold);
    for (int k = 0; k < 4; k++) drive_digit(k, v[k*4 +: 4], lit[k], hold);
    drive(4'hf, 7'h7f, 1'b1, 10);
  endtask

  always @(negedge clk) begin
    if (an_err) an_err_cnt++;
    if (stale) stale_cnt++;
    if (frame_valid) begin
      frame_t f;
      fv_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_frame", 32'(frame_value), 32'hffffffff);
      end else begin
        f = exp_q.pop_front();
        chk("frame_value", 32'(frame_value), 32'(f.value));
        chk("frame_dp", 32'(frame_dp), 32'(f.dpl));
        chk("seg_err", 32'(seg_err), 32'(f.err));
        chk("frame_changed", 32'(frame_changed), 32'(f.chg));
      end
    end else begin
      chk("changed_without_valid", 32'(frame_changed), 32'h0);
    end
  end

  initial begin
    int fv0, ae0, st0;
    #12;
    chk("reset_outputs", {frame_value, frame_dp, seg_err, frame_valid, frame_changed,
                          an_err, stale}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #2;
    drive(4'hf, 7'h7f, 1'b1, 6);

    fv0 = fv_cnt;
    push_exp(16'h1234, 4'h0, 4'h0);
    scan(16'h1234, 4'h0, 8);
    chk("first_scan_frames", fv_cnt, fv0 + 1);
    push_exp(16'h1234, 4'h0, 4'h0);
    scan(16'h1234, 4'h0, 8);
    chk("repeat_scan_frames", fv_cnt, fv0 + 2);
    chk("no_an_err_yet", an_err_cnt, 0);

    // 3-cycle holds never settle
    fv0 = fv_cnt;
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < 4; k++) drive_digit(k, 4'(k + 5), 1'b0, 3);
    drive(4'hf, 7'h7f, 1'b1, 12);
    chk("fast_toggle_frames", fv_cnt, fv0);
    ae0 = an_err_cnt;
    drive(4'b1100, 7'h00, 1'b1, 3);
    drive(4'hf, 7'h7f, 1'b1, 8);
    chk("an_err_hold3", an_err_cnt, ae0);
    drive(4'b1100, 7'h00, 1'b1, 4);
    drive(4'hf, 7'h7f, 1'b1, 8);
    chk("an_err_hold4", an_err_cnt, ae0 + 1);
    push_exp(16'hdcba, 4'h0, 4'h0);
    scan(16'hdcba, 4'h0, 4);
    chk("hold4_scan_frames", fv_cnt, fv0 + 1);

    // digit 2 blank with its decimal point lit
    push_exp(16'h0000, 4'b0100, 4'b0100);
    drive_digit(0, 4'h0, 1'b0, 8);
    drive_digit(1, 4'h0, 1'b0, 8);
    drive(4'b1011, 7'b1111111, 1'b0, 8);
    drive_digit(3, 4'h0, 1'b0, 8);
    drive(4'hf, 7'h7f, 1'b1, 10);
    chk("seg_err_frames", fv_cnt, fv0 + 2);

    // an_err in mid-frame leaves the captured digits intact
    ae0 = an_err_cnt;
    push_exp(16'h8765, 4'b1000, 4'h0);
    drive_digit(0, 4'h5, 1'b0, 8);
    drive_digit(1, 4'h6, 1'b0, 8);
    drive(4'b1100, 7'h00, 1'b1, 8);
    drive(4'hf, 7'h7f, 1'b1, 8);
    drive_digit(2, 4'h7, 1'b0, 8);
    drive_digit(3, 4'h8, 1'b1, 8);
    drive(4'hf, 7'h7f, 1'b1, 10);
    chk("an_err_mid_frame", an_err_cnt, ae0 + 1);
    chk("mid_frame_frames", fv_cnt, fv0 + 3);

    // partial frame discarded after 32 idle cycles
    st0 = stale_cnt;
    drive_digit(0, 4'h1, 1'b0, 8);
    drive_digit(1, 4'h2, 1'b0, 8);
    drive(4'hf, 7'h7f, 1'b1, 20);
    chk("no_early_stale", stale_cnt, st0);
    drive(4'hf, 7'h7f, 1'b1, 40);
    chk("stale_once", stale_cnt, st0 + 1);
    chk("held_after_stale", 32'(frame_value), 32'h8765);
    chk("no_frame_on_stale", fv_cnt, fv0 + 3);
    push_exp(16'h6789, 4'h0, 4'h0);
    scan(16'h6789, 4'h0, 8);
    chk("after_stale_frames", fv_cnt, fv0 + 4);

    // asynchronous reset mid-frame
    drive_digit(0, 4'h3, 1'b0, 8);
    drive_digit(1, 4'h3, 1'b0, 8);
    #1;
    reset = 1'b0;
    #1;
    chk("async_reset_outputs", {frame_value, frame_dp, seg_err, frame_valid, frame_changed,
                                an_err, stale}, 32'h0);
    an = 4'hf;
    sseg = 7'h7f;
    dp = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #2;
    drive(4'hf, 7'h7f, 1'b1, 6);
    last_value = 16'h0;
    push_exp(16'h4321, 4'h0, 4'h0);
    scan(16'h4321, 4'h0, 8);
    chk("post_reset_frames", fv_cnt, fv0 + 5);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/sseg_scan_capture.md
Name: sseg_scan_capture

Overview:
- Receive-side counterpart of the four-digit time-multiplexed 7-segment display driver.
- Watches the active-low an/sseg/dp bus, samples each digit once its pattern has settled, and decodes segments back to hex nibbles.
- Once all four digits are captured, presents them as one 16-bit frame.
- Used for on-chip self-check and as a bench monitor for stopwatch/timer displays.

Parameters:
- SETTLE_CYCLES, 4: consecutive cycles {an,sseg,dp} must be unchanged before a sample is taken; legal range 2..255.
- TIMEOUT_CYCLES, 1048576: cycles without any sample before a partial frame is discarded; legal range 16..2^24.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- an  input  4  digit enables, active-low; an[0] is the rightmost digit (digit 0).
- sseg  input  7  segments, active-low; sseg[0]=a, [1]=b, [2]=c, [3]=d, [4]=e, [5]=f, [6]=g.
- dp  input  1  decimal point, active-low.
- frame_value  output  16  {digit3,digit2,digit1,digit0} nibbles of the last completed frame.
- frame_dp  output  4  decimal-point state per digit, active-high (1 = lit), of the last frame.
- seg_err  output  4  per-digit flag: the segment pattern was not a legal hex glyph in the last frame.
- frame_valid  output  1  one-cycle pulse when frame_value/frame_dp/seg_err update.
- frame_changed  output  1  one-cycle pulse, coincident with frame_valid, when frame_value differs from the previous frame.
- an_err  output  1  one-cycle pulse when a settled sample has more than one an bit low.
- stale  output  1  one-cycle pulse when a partial frame is discarded by timeout.

Behaviour:
- Reset (reset=0, asynchronous): every output is 0, all internal registers are 0, the capture mask is 0, and the FSM is in IDLE. Release is synchronous to clk.
- Input stage: {an,sseg,dp} is registered once (bus_q). All downstream logic uses bus_q.
- Settle counter:
  - Clears to 0 on any cycle where bus_q differs from its previous value.
  - Otherwise increments, saturating at SETTLE_CYCLES.
  - Exactly one sample strobe fires on the cycle the counter reaches SETTLE_CYCLES-1, i.e. after SETTLE_CYCLES identical bus_q cycles.
  - No further strobes fire until the bus changes.
- Sample classification:
  - an == 4'b1111: blank; ignored, no state change.
  - Exactly one an bit low: digit k = index of the low bit. This is a valid sample.
  - Two or more an bits low: an_err pulses on the cycle after the strobe; the capture mask is not altered.
- Segment decode uses active-low codes, listed as sseg[6:0]:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - Any other pattern gives nibble 0 and sets the error bit for that digit.
- On a valid sample of digit k: store the nibble, ~dp and the error bit into slot k, and set mask[k]. Resampling a digit already in the mask overwrites slot k.
- FSM:
  - IDLE: on the first valid sample, go to COLLECT.
  - COLLECT: when mask becomes 4'b1111, on the next cycle:
    - copy the slots to frame_value/frame_dp/seg_err;
    - pulse frame_valid;
    - pulse frame_changed if the new frame_value differs from the held one;
    - clear mask and return to IDLE.
  - The very first frame after reset always pulses frame_changed if its value is nonzero.
  - Latency: frame_valid is 2 cycles after the sample strobe that completes the mask.
- Timeout:
  - In COLLECT, a cycle counter clears on each valid sample.
  - On reaching TIMEOUT_CYCLES: clear mask, pulse stale for one cycle, return to IDLE.
  - frame_* outputs are held.
- Simultaneous events:
  - If the completing sample and the timeout fall on the same cycle, the sample wins; no stale pulse.
  - A sample arriving on the output-update cycle belongs to the next frame.
- Outputs are held between frames; only the pulse outputs return to 0.
- Reset asserted mid-frame discards all partial state immediately.

Test Plan:
- Scan digits 0..3 showing 4,3,2,1 (sseg 0011001, 0110000, 0100100, 1111001), each held 8 cycles, dp high -> frame_valid once, frame_value=16'h1234, frame_dp=0, seg_err=0, frame_changed=1. The same scan repeated -> frame_valid=1, frame_changed=0.
- Patterns change every 3 cycles with SETTLE_CYCLES=4 -> no sample, no frame_valid. Hold for exactly 4 cycles -> exactly one sample.
- Digit 2 shows sseg=1111111 with dp low; others show 0 -> frame_value=16'h0000, seg_err=4'b0100, frame_dp=4'b0100.
- an=4'b1100 held 8 cycles -> an_err pulses once, mask unchanged. an=4'b1111 -> no effect.
- Digits 0 and 1 are captured, then the bus goes idle for TIMEOUT_CYCLES (TIMEOUT_CYCLES=32 in the bench) -> stale pulses once. The following full scan of 9,8,7,6 yields 16'h6789.
- reset driven low mid-frame, asynchronously between clock edges -> all outputs 0 immediately. After release, a full scan produces a normal frame.
